multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath. Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, register file, IR/PC and the single unified memory port.
- Memory is accessed through a REQ/READY handshake with a wait-state timeout.
- Supports add, sub, and, or, slt, addi, lw, sw and beq, using the existing ALU_OP encoding.

---
 rtl/multicycle_control_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer.
// Moves each instruction through fetch, decode, execute, memory and writeback.
// Drives the shared ALU, register file, IR/PC and the unified memory port.
// Memory accesses use a REQ/READY handshake. A wait-state timeout moves the
// sequencer into a sticky fault state, which only reset can clear.
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15,  // 1..255 wait cycles before a memory timeout
  parameter int CNT_W      = 16   // retired-instruction counter width
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       OPCODE,
  input  logic [5:0]       FUNCT,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic             IORD,
  output logic             IR_WRITE,
  output logic             PC_WRITE,
  output logic             PC_SRC,
  output logic             TARGET_WRITE,
  output logic             REG_DST,
  output logic             REG_WRITE,
  output logic             MEM2REG,
  output logic             EX_TOP,
  output logic             ALU_SRC_A,
  output logic [1:0]       ALU_SRC_B,
  output logic [3:0]       ALU_OP,
  output logic             FAULT,
  output logic [1:0]       FAULT_CODE,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // Value of the wait counter in the last cycle allowed without MEM_READY.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic [1:0] fault_code;
  logic [1:0] fault_next;
  logic       retire;
  logic       mem_state;
  logic       timeout;
  logic       r_legal;
  logic [3:0] r_alu_op;

  // Decode FUNCT into an R-type ALU operation and flag any unsupported code.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    r_legal  = 1'b1;
    r_alu_op = ALU_AND;
    case (FUNCT)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b101010: r_alu_op = ALU_SLT;
      default:   r_legal  = 1'b0;
    endcase
  end

  // A memory state is timing out when the final permitted wait cycle passes without READY.
  always_comb begin
    mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    timeout   = mem_state && !MEM_READY && (wait_cnt == WAIT_LAST);
  end

  // Choose the next state, the fault cause to record and the retire strobe.
  always_comb begin
    next_state = state;
    fault_next = 2'b00;
    retire     = 1'b0;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        if (MEM_READY)    next_state = S_DECODE;
        else if (timeout) begin
          next_state = S_FAULT;
          fault_next = CODE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (OPCODE == OP_RTYPE && r_legal) next_state = S_EXEC_R;
        else if (OPCODE == OP_ADDI)        next_state = S_EXEC_I;
        else if (OPCODE == OP_LW || OPCODE == OP_SW) next_state = S_ADDR;
        else if (OPCODE == OP_BEQ)         next_state = S_BRANCH;
        else begin
          next_state = S_FAULT;
          fault_next = CODE_ILLEGAL;
        end
      end
      S_EXEC_R: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_ADDR:   next_state = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MEM_READY)    next_state = S_WB_MEM;
        else if (timeout) begin
          next_state = S_FAULT;
          fault_next = CODE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (MEM_READY) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (timeout) begin
          next_state = S_FAULT;
          fault_next = CODE_TIMEOUT;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_IDLE;
    endcase
  end

  // State, wait counter, fault cause and retired-instruction counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      fault_code  <= 2'b00;
      INSTR_COUNT <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      if (next_state != state)        wait_cnt <= 8'd0;
      else if (mem_state && !MEM_READY) wait_cnt <= wait_cnt + 8'd1;
      if (next_state == S_FAULT && state != S_FAULT) fault_code <= fault_next;
      if (retire) INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
    end
  end

  // Datapath controls decoded from state, with MEM_READY/ZERO qualifiers where needed.
  always_comb begin
    MEM_REQ      = 1'b0;
    MEM_WE       = 1'b0;
    IORD         = 1'b0;
    IR_WRITE     = 1'b0;
    PC_WRITE     = 1'b0;
    PC_SRC       = 1'b0;
    TARGET_WRITE = 1'b0;
    REG_DST      = 1'b0;
    REG_WRITE    = 1'b0;
    MEM2REG      = 1'b0;
    EX_TOP       = 1'b0;
    ALU_SRC_A    = 1'b0;
    ALU_SRC_B    = 2'b00;
    ALU_OP       = 4'b0000;
    FAULT        = 1'b0;
    FAULT_CODE   = fault_code;
    case (state)
      S_FETCH: begin
        MEM_REQ   = 1'b1;
        ALU_SRC_B = 2'b01;
        ALU_OP    = ALU_ADD;
        IR_WRITE  = MEM_READY;
        PC_WRITE  = MEM_READY;
      end
      S_DECODE: begin
        ALU_SRC_B    = 2'b11;
        ALU_OP       = ALU_ADD;
        EX_TOP       = 1'b1;
        TARGET_WRITE = 1'b1;
      end
      S_EXEC_R: begin
        ALU_SRC_A = 1'b1;
        ALU_OP    = r_alu_op;
      end
      S_EXEC_I, S_ADDR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'b10;
        EX_TOP    = 1'b1;
        ALU_OP    = ALU_ADD;
      end
      S_MEM_RD: begin
        MEM_REQ = 1'b1;
        IORD    = 1'b1;
      end
      S_MEM_WR: begin
        MEM_REQ = 1'b1;
        MEM_WE  = 1'b1;
        IORD    = 1'b1;
      end
      S_WB_R: begin
        REG_WRITE = 1'b1;
        REG_DST   = 1'b1;
        MEM2REG   = 1'b1;
      end
      S_WB_I: begin
        REG_WRITE = 1'b1;
        MEM2REG   = 1'b1;
      end
      S_WB_MEM: REG_WRITE = 1'b1;
      S_BRANCH: begin
        ALU_SRC_A = 1'b1;
        ALU_OP    = ALU_SUB;
        PC_WRITE  = ZERO;
        PC_SRC    = 1'b1;
      end
      S_FAULT:  FAULT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm.
// The driver walks each instruction through a per-instruction model of the
// sequencer built from the ISA rules. For every cycle it drives, the driver
// queues the expected control word and counter value. A monitor samples the
// DUT on each falling edge and compares it with the queued entry.
module tb_multicycle_control_fsm;

  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 4;  // narrow so the retire counter wraps during the random run

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, target_write;
    logic       reg_dst, reg_write, mem2reg, ex_top, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       fault;
    logic [1:0] fault_code;
  } ctl_t;

  typedef struct {
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [5:0]       OPCODE = '0;
  logic [5:0]       FUNCT = '0;
  logic             ZERO = 1'b0;
  logic             MEM_READY = 1'b0;
  logic             MEM_REQ, MEM_WE, IORD, IR_WRITE, PC_WRITE, PC_SRC, TARGET_WRITE;
  logic             REG_DST, REG_WRITE, MEM2REG, EX_TOP, ALU_SRC_A, FAULT;
  logic [1:0]       ALU_SRC_B, FAULT_CODE;
  logic [3:0]       ALU_OP;
  logic [CNT_W-1:0] INSTR_COUNT;

  multicycle_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .IORD(IORD),
    .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC),
    .TARGET_WRITE(TARGET_WRITE), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
    .MEM2REG(MEM2REG), .EX_TOP(EX_TOP), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .FAULT(FAULT),
    .FAULT_CODE(FAULT_CODE), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] m_cnt = '0;   // model's retired count
  logic [1:0]       m_code = 2'b00;

  // Compare DUT outputs with the oldest expectation, away from the rising edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t got;
      e   = exp_q.pop_front();
      got = {MEM_REQ, MEM_WE, IORD, IR_WRITE, PC_WRITE, PC_SRC, TARGET_WRITE,
             REG_DST, REG_WRITE, MEM2REG, EX_TOP, ALU_SRC_A, ALU_SRC_B, ALU_OP,
             FAULT, FAULT_CODE};
      total++;
      if (got !== e.ctl || INSTR_COUNT !== e.cnt) begin
        bad++;
        $display("FAIL %s @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.tag, $time, got, INSTR_COUNT, e.ctl, e.cnt);
      end
    end
  end

  // ---------------- reference model: control words from the ISA rules ----------------
  function automatic ctl_t w_fetch(input logic rdy);
    ctl_t w = '0;
    w.mem_req = 1'b1; w.alu_src_b = 2'b01; w.alu_op = 4'b0010;
    w.ir_write = rdy; w.pc_write = rdy;
    return w;
  endfunction

  function automatic ctl_t w_decode();
    ctl_t w = '0;
    w.alu_src_b = 2'b11; w.alu_op = 4'b0010; w.ex_top = 1'b1; w.target_write = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_imm_alu();  // addi execute and lw/sw address
    ctl_t w = '0;
    w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; w.ex_top = 1'b1; w.alu_op = 4'b0010;
    return w;
  endfunction

  function automatic ctl_t w_exec_r(input logic [3:0] op);
    ctl_t w = '0;
    w.alu_src_a = 1'b1; w.alu_op = op;
    return w;
  endfunction

  function automatic ctl_t w_mem(input logic wr);
    ctl_t w = '0;
    w.mem_req = 1'b1; w.iord = 1'b1; w.mem_we = wr;
    return w;
  endfunction

  function automatic ctl_t w_wb(input logic dst, input logic m2r);
    ctl_t w = '0;
    w.reg_write = 1'b1; w.reg_dst = dst; w.mem2reg = m2r;
    return w;
  endfunction

  function automatic ctl_t w_branch(input logic z);
    ctl_t w = '0;
    w.alu_src_a = 1'b1; w.alu_op = 4'b0110; w.pc_write = z; w.pc_src = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_fault(input logic [1:0] code);
    ctl_t w = '0;
    w.fault = 1'b1; w.fault_code = code;
    return w;
  endfunction

  // R-type FUNCT table: returns {legal, alu_op}.
  function automatic logic [4:0] r_table(input logic [5:0] f);
    case (f)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b101010: return 5'b1_0111;
      default:   return 5'b0_0000;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input ctl_t c, input string tag);
    exp_t e;
    e.ctl = c; e.cnt = m_cnt; e.tag = tag;
    exp_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  // Randomise inputs the current state must ignore.
  task automatic noise();
    MEM_READY = 1'($urandom);
    ZERO      = 1'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    RST_N = 1'b0;
    m_cnt = '0; m_code = 2'b00;
    for (int i = 0; i < cycles; i++) begin
      noise();
      step('0, "reset");
    end
    RST_N = 1'b1;
    noise();
    step('0, "idle");
  endtask

  task automatic hold_fault(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      noise();
      OPCODE = 6'($urandom);
      step(w_fault(m_code), "fault_hold");
    end
  endtask

  // Memory handshake: READY arrives after wait_n idle cycles; a timeout ends in a fault.
  // kind 0 = fetch, 1 = load, 2 = store.
  task automatic mem_phase(input int wait_n, input int kind, output bit faulted);
    bit done = 0;
    faulted = 0;
    for (int i = 1; !done; i++) begin
      logic rdy;
      rdy       = (i > wait_n);
      MEM_READY = rdy;
      ZERO      = 1'($urandom);
      if (kind == 0) step(w_fetch(rdy), "fetch");
      else           step(w_mem(kind == 2), (kind == 2) ? "mem_wr" : "mem_rd");
      if (rdy) done = 1;
      else if (i == WAIT_LIMIT) begin
        m_code = 2'b10; faulted = 1; done = 1;
      end
    end
  endtask

  // One whole instruction; returns 1 when it ended in the fault state.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int fw, input int mw, output bit faulted);
    logic [4:0] rt;
    OPCODE = 6'($urandom);
    FUNCT  = 6'($urandom);
    mem_phase(fw, 0, faulted);
    if (faulted) return;
    OPCODE = op; FUNCT = f;
    noise();
    step(w_decode(), "decode");
    rt = r_table(f);
    noise();
    if (op == 6'b000000 && rt[4]) begin
      step(w_exec_r(rt[3:0]), "exec_r");
      noise();
      step(w_wb(1'b1, 1'b1), "wb_r");
      m_cnt++;
    end else if (op == 6'b001000) begin
      step(w_imm_alu(), "exec_i");
      noise();
      step(w_wb(1'b0, 1'b1), "wb_i");
      m_cnt++;
    end else if (op == 6'b100011) begin
      step(w_imm_alu(), "addr_lw");
      mem_phase(mw, 1, faulted);
      if (faulted) return;
      noise();
      step(w_wb(1'b0, 1'b0), "wb_mem");
      m_cnt++;
    end else if (op == 6'b101011) begin
      step(w_imm_alu(), "addr_sw");
      mem_phase(mw, 2, faulted);
      if (faulted) return;
      m_cnt++;
    end else if (op == 6'b000100) begin
      ZERO = z;
      step(w_branch(z), "branch");
      m_cnt++;
    end else begin
      m_code  = 2'b01;
      faulted = 1;
    end
  endtask

  // Wrapper for instructions expected to complete normally.
  task automatic run_ok(input logic [5:0] op, input logic [5:0] f, input logic z,
                        input int fw, input int mw);
    bit flt;
    run_instr(op, f, z, fw, mw, flt);
    if (flt) begin
      hold_fault(2);
      do_reset(2);
    end
  endtask

  task automatic run_fault(input logic [5:0] op, input logic [5:0] f,
                           input int fw, input int mw, input int hold);
    bit flt;
    run_instr(op, f, 1'b0, fw, mw, flt);
    hold_fault(hold);
    do_reset(2);
  endtask

  logic [5:0] kind_op[9] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b001000, 6'b100011, 6'b101011, 6'b000100};
  logic [5:0] kind_fn[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b000000, 6'b000000, 6'b000000, 6'b000000};

  initial begin
    @(posedge CLK); #1;
    do_reset(2);

    // add with zero wait states, then lw with 3 wait cycles in fetch and load
    run_ok(6'b000000, 6'b100000, 1'b0, 0, 0);
    run_ok(6'b100011, 6'b000000, 1'b0, 3, 3);
    run_ok(6'b101011, 6'b010101, 1'b0, 0, 0);
    run_ok(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_ok(6'b000100, 6'b000000, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) run_ok(kind_op[k], kind_fn[k], 1'b0, 0, 0);
    run_ok(6'b001000, 6'b111111, 1'b0, 1, 0);

    // READY arriving on the last allowed wait cycle still makes progress
    run_ok(6'b000000, 6'b100000, 1'b0, WAIT_LIMIT - 1, 0);
    run_ok(6'b100011, 6'b000000, 1'b0, 0, WAIT_LIMIT - 1);
    run_ok(6'b101011, 6'b000000, 1'b0, 2, WAIT_LIMIT - 1);

    // random instruction mix with occasional wait states; the counter wraps
    for (int n = 0; n < 40; n++) begin
      int k;
      int fw;
      int mw;
      k  = int'($urandom_range(0, 8));
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      run_ok(kind_op[k], (kind_op[k] == 6'b000000) ? kind_fn[k] : 6'($urandom),
             1'($urandom), fw, mw);
    end

    // illegal encodings: unlisted FUNCT and an unsupported opcode
    run_fault(6'b000000, 6'b000111, 0, 0, 20);
    run_ok(6'b000000, 6'b100010, 1'b0, 0, 0);
    run_fault(6'b000010, 6'b100000, 0, 0, 4);

    // memory timeouts in fetch, load and store
    run_fault(6'b000000, 6'b100000, WAIT_LIMIT, 0, 5);
    run_fault(6'b100011, 6'b000000, 0, WAIT_LIMIT, 3);
    run_fault(6'b101011, 6'b000000, 1, WAIT_LIMIT + 4, 3);
    run_ok(6'b000100, 6'b000000, 1'b1, 0, 0);

    @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
